// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, state encoding and address slicing for the data cache
package dcache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W     = BLOCK_BYTES * 8;
  localparam int MEM_ADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } stateT;

  function automatic logic [TAG_W-1:0] addrTag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addrIndex(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addrOffset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  // Word-organised memory sees the block number, i.e. the address without its offset.
  function automatic logic [MEM_ADDR_W-1:0] blockAddr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: MEM_ADDR_W];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - cpu-side and memory-side buses of the data cache
interface dcache_cpu_if import dcache_pkg::*;;
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [7:0]        WRITEDATA;
  logic [7:0]        READDATA;
  logic              BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if import dcache_pkg::*;;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0]    mem_writedata;
  logic [BLOCK_W-1:0]    mem_readdata;
  logic                  mem_busywait;

  modport master (output mem_read, mem_write, mem_address, mem_writedata,
                  input mem_readdata, mem_busywait);
  modport slave  (input mem_read, mem_write, mem_address, mem_writedata,
                  output mem_readdata, mem_busywait);
endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/dirty/tag/data storage with byte-write and block-fill ports
module dcache_array import dcache_pkg::*; (
  input  logic                clk,
  input  logic                rstN,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                byteWe,
  input  logic [7:0]          byteData,
  input  logic                fillEn,
  input  logic [INDEX_W-1:0]  fillIndex,
  input  logic [TAG_W-1:0]    fillTag,
  input  logic [BLOCK_W-1:0]  fillData,
  output logic                hit,
  output logic [7:0]          readByte,
  output logic                lineValid,
  output logic                lineDirty,
  output logic [TAG_W-1:0]    lineTag,
  output logic [BLOCK_W-1:0]  lineData
);

  logic [NUM_BLOCKS-1:0] validBits;
  logic [NUM_BLOCKS-1:0] dirtyBits;
  logic [TAG_W-1:0]      tagMem  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    dataMem [NUM_BLOCKS];

  // Line storage: a refill replaces the whole line clean, a store marks it dirty.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      validBits <= '0;
      dirtyBits <= '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        tagMem[i]  <= '0;
        dataMem[i] <= '0;
      end
    end else if (fillEn) begin
      dataMem[fillIndex]   <= fillData;
      tagMem[fillIndex]    <= fillTag;
      validBits[fillIndex] <= 1'b1;
      dirtyBits[fillIndex] <= 1'b0;
    end else if (byteWe) begin
      dataMem[index][{offset, 3'b000} +: 8] <= byteData;
      dirtyBits[index]                      <= 1'b1;
    end
  end

  assign lineValid = validBits[index];
  assign lineDirty = dirtyBits[index];
  assign lineTag   = tagMem[index];
  assign lineData  = dataMem[index];
  assign hit       = lineValid && (lineTag == tag);
  assign readByte  = lineData[{offset, 3'b000} +: 8];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller
module dcache_ctrl import dcache_pkg::*; (
  input  logic         CLK,
  input  logic         RESET,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem
);

  stateT                 state;
  logic                  started;
  logic                  request;
  logic                  hit;
  logic [7:0]            readByte;
  logic                  lineValid;
  logic                  lineDirty;
  logic [TAG_W-1:0]      lineTag;
  logic [BLOCK_W-1:0]    lineData;
  logic                  byteWe;
  logic                  fillEn;
  logic                  xferDone;

  assign request  = cpu.READ | cpu.WRITE;
  assign xferDone = started && !mem.mem_busywait;
  // Stores only land in IDLE on a hit; a missing store is replayed here after its refill.
  assign byteWe   = (state == IDLE) && hit && cpu.WRITE;
  assign fillEn   = (state == MEM_READ) && xferDone;

  // Reset gates the cpu-facing outputs so the core sees no stall while the cache is held.
  assign cpu.BUSYWAIT = RESET && request && !((state == IDLE) && hit);
  assign cpu.READDATA = (RESET && cpu.READ) ? readByte : 8'h00;

  dcache_array uArray (
    .clk       (CLK),
    .rstN      (RESET),
    .index     (addrIndex(cpu.ADDRESS)),
    .tag       (addrTag(cpu.ADDRESS)),
    .offset    (addrOffset(cpu.ADDRESS)),
    .byteWe    (byteWe),
    .byteData  (cpu.WRITEDATA),
    .fillEn    (fillEn),
    .fillIndex (mem.mem_address[INDEX_W-1:0]),
    .fillTag   (mem.mem_address[MEM_ADDR_W-1 -: TAG_W]),
    .fillData  (mem.mem_readdata),
    .hit       (hit),
    .readByte  (readByte),
    .lineValid (lineValid),
    .lineDirty (lineDirty),
    .lineTag   (lineTag),
    .lineData  (lineData)
  );

  // Miss FSM: a transfer ends on the first idle memory cycle after memory has reported busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state             <= IDLE;
      started           <= 1'b0;
      mem.mem_read      <= 1'b0;
      mem.mem_write     <= 1'b0;
      mem.mem_address   <= '0;
      mem.mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          started <= 1'b0;
          if (request && !hit) begin
            if (lineValid && lineDirty) begin
              state             <= MEM_WRITE;
              mem.mem_write     <= 1'b1;
              mem.mem_address   <= {lineTag, addrIndex(cpu.ADDRESS)};
              mem.mem_writedata <= lineData;
            end else begin
              state           <= MEM_READ;
              mem.mem_read    <= 1'b1;
              mem.mem_address <= blockAddr(cpu.ADDRESS);
            end
          end
        end
        MEM_WRITE: begin
          if (xferDone) begin
            state           <= MEM_READ;
            started         <= 1'b0;
            mem.mem_write   <= 1'b0;
            mem.mem_read    <= 1'b1;
            mem.mem_address <= blockAddr(cpu.ADDRESS);
          end else if (mem.mem_busywait) begin
            started <= 1'b1;
          end
        end
        MEM_READ: begin
          if (xferDone) begin
            state        <= IDLE;
            started      <= 1'b0;
            mem.mem_read <= 1'b0;
          end else if (mem.mem_busywait) begin
            started <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          started       <= 1'b0;
          mem.mem_read  <= 1'b0;
          mem.mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache placed directly downstream of the cpu datapath.
- Consumes the ALU result as the byte address and register-file data for stores.
- Returns load data to the register-file write port and stalls the cpu (PC hold, register write hold) through BUSYWAIT.
- Refills and evicts 32-bit blocks from word-organised data memory over a busywait handshake.

Parameters:
- NUM_BLOCKS, 8, cache lines; index width = log2(NUM_BLOCKS) = 3.
- BLOCK_BYTES, 4, bytes per line; offset width 2; block = 32 bits.
- ADDR_W, 8, cpu byte-address width; tag width = ADDR_W-5 = 3.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  cpu load request, held stable while BUSYWAIT=1.
- WRITE  in  1  cpu store request, held stable while BUSYWAIT=1.
- ADDRESS  in  8  cpu byte address {tag[7:5], index[4:2], offset[1:0]}.
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte, valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  cpu stall.
- mem_read  out  1  block refill request.
- mem_write  out  1  block write-back request.
- mem_address  out  6  block address {tag,index}.
- mem_writedata  out  32  evicted block, byte0 in [7:0].
- mem_readdata  in  32  refill block.
- mem_busywait  in  1  memory busy.

Behaviour:
- Arrays: per line valid, dirty, tag[2:0], data[31:0].
- Reset (RESET=0, async): all valid/dirty=0, state=IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, READDATA=0, BUSYWAIT=0. Reset mid-refill or mid-write-back abandons the transfer immediately; no line is updated.
- Request = READ|WRITE. If both are high, WRITE wins.
- hit = valid[index] && tag[index]==ADDRESS[7:5], combinational.
- READDATA: combinational byte select of data[index] by offset; 0 when READ=0.
- BUSYWAIT (combinational) = request && !(state==IDLE && hit). It is 0 in any cycle with no request.
- State IDLE:
  - Read hit: completes in the same cycle, no array change.
  - Write hit: at the posedge, the byte is written, dirty[index]=1, valid stays 1.
  - Miss with (!valid or !dirty): go to MEM_READ.
  - Miss with valid && dirty: go to MEM_WRITE.
- State MEM_WRITE:
  - Drive mem_write=1, mem_address={tag[index],index}, mem_writedata=data[index].
  - Transfer completes at the first posedge where mem_busywait=0 after it has been sampled 1 in this state (a started flag is cleared on state entry).
  - On completion: go to MEM_READ. The line is not invalidated.
- State MEM_READ:
  - Drive mem_read=1, mem_address=ADDRESS[7:2].
  - Same completion rule as MEM_WRITE.
  - On completion: data[index]=mem_readdata, tag=ADDRESS[7:5], valid=1, dirty=0; go to IDLE.
- After refill, the request re-evaluates as a hit. Read miss: BUSYWAIT falls in the first IDLE cycle after refill. Write miss: the byte is written at the end of that cycle.
- Latency: hit = 0 stall cycles. Clean miss = refill duration + 1 cycle. Dirty miss = write-back + refill + 1 cycle.
- mem_read and mem_write are never high together and are both 0 in IDLE.
- A request dropped while not in IDLE is illegal; the transfer still completes and the line is still filled.
- No write-allocate bypass: write misses allocate.

Decomposition:
- Shared package dcache_pkg:
  - state enum IDLE / MEM_READ / MEM_WRITE.
  - TAG_W, INDEX_W, OFFSET_W.
  - address-field slice functions.
- One natural sub-module, dcache_array:
  - valid/dirty/tag/data storage with async clear.
  - byte-write port and block-fill port.
  - combinational hit and byte read.
- The FSM and handshake stay in dcache_ctrl.

Test Plan:
- Reset then READ addr 0x14 → BUSYWAIT=1, mem_read=1, mem_address=0x05. Memory returns 0xDDCCBBAA after 5 busy cycles → one cycle later BUSYWAIT=0, READDATA=0xAA.
- After fill, READ 0x17 → BUSYWAIT=0 same cycle, READDATA=0xDD, mem_read stays 0.
- WRITE 0x16 data 0x5A (hit) → no stall; then READ 0x16 → 0x5A, dirty[5]=1.
- READ 0x34 (same index 5, tag 1, dirty line) → mem_write=1, mem_address=0x05, mem_writedata=0xDD5ABBAA. Then mem_read=1, mem_address=0x0D; after refill READDATA=byte0 of the new block.
- Assert RESET low during MEM_READ → mem_read=0, BUSYWAIT=0 immediately. After release, READ 0x14 misses again.
- READ=WRITE=1 at 0x20 data 0x11 on a clean miss → refill, then byte written. A later READ 0x20 → 0x11.
